// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that lends the single status LED to one requester at a time
// and plays a burst of N on/off blinks, followed by an inter-burst gap.
module led_blink_arbiter #(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 5_000_000,
  parameter int CNT_W    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*CNT_W-1:0]   cnt_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    busy_o,
  output logic                    led_o
);

  localparam int TW = $clog2(2*TICK_DIV);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [TW-1:0]    PHASE_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]    GAP_LAST   = TW'(2*TICK_DIV - 1);
  localparam logic [PW-1:0]    LAST_RST   = PW'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0   = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t            state_r, state_nx_s;
  logic [TW-1:0]     tick_r, tick_nx_s;
  logic [CNT_W-1:0]  rem_r, rem_nx_s;
  logic [PW-1:0]     last_r, last_nx_s;
  logic [NREQ-1:0]   gnt_r, gnt_nx_s;
  logic [NREQ-1:0]   done_r, done_nx_s;
  logic              busy_r, busy_nx_s;
  logic              led_r, led_nx_s;

  logic              sel_vld_s;
  logic [PW-1:0]     sel_idx_s;
  logic [CNT_W-1:0]  sel_cnt_s;
  logic              phase_end_s;

  // State and registered outputs; last_r starts at NREQ-1 so requester 0 wins first
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      tick_r  <= '0;
      rem_r   <= '0;
      last_r  <= LAST_RST;
      gnt_r   <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
      led_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      tick_r  <= tick_nx_s;
      rem_r   <= rem_nx_s;
      last_r  <= last_nx_s;
      gnt_r   <= gnt_nx_s;
      done_r  <= done_nx_s;
      busy_r  <= busy_nx_s;
      led_r   <= led_nx_s;
    end
  end

  // Round-robin search upward from last_r+1 with wrap; the first hit wins
  always_comb begin
    sel_vld_s = 1'b0;
    sel_idx_s = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!sel_vld_s && req_i[(int'(last_r) + off) % NREQ]) begin
        sel_vld_s = 1'b1;
        sel_idx_s = PW'((int'(last_r) + off) % NREQ);
      end else begin
        sel_vld_s = sel_vld_s;
        sel_idx_s = sel_idx_s;
      end
    end
    sel_cnt_s = cnt_i[int'(sel_idx_s)*CNT_W +: CNT_W];
  end

  // Next-state logic, phase timing and burst bookkeeping
  always_comb begin
    state_nx_s  = state_r;
    rem_nx_s    = rem_r;
    last_nx_s   = last_r;
    phase_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_vld_s) begin
          state_nx_s = ST_ON;
          rem_nx_s   = (sel_cnt_s == '0) ? CNT_ONE : sel_cnt_s;
          last_nx_s  = sel_idx_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ON: begin
        phase_end_s = (tick_r == PHASE_LAST);
        if (phase_end_s) begin
          state_nx_s = ST_OFF;
        end else begin
          state_nx_s = ST_ON;
        end
      end
      ST_OFF: begin
        phase_end_s = (tick_r == PHASE_LAST);
        if (phase_end_s) begin
          rem_nx_s   = rem_r - CNT_ONE;
          state_nx_s = (rem_r == CNT_ONE) ? ST_GAP : ST_ON;
        end else begin
          state_nx_s = ST_OFF;
        end
      end
      ST_GAP: begin
        phase_end_s = (tick_r == GAP_LAST);
        if (phase_end_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    if ((state_nx_s != state_r) || (state_r == ST_IDLE)) begin
      tick_nx_s = '0;
    end else begin
      tick_nx_s = tick_r + TW'(1);
    end
  end

  // Output next values, registered above so nothing leaks combinationally to the pins
  always_comb begin
    gnt_nx_s  = gnt_r;
    done_nx_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (sel_vld_s) begin
          gnt_nx_s = ONE_HOT0 << sel_idx_s;
        end else begin
          gnt_nx_s = '0;
        end
      end
      ST_GAP: begin
        if (phase_end_s) begin
          gnt_nx_s  = '0;
          done_nx_s = gnt_r;
        end else begin
          gnt_nx_s  = gnt_r;
        end
      end
      default: begin
        gnt_nx_s = gnt_r;
      end
    endcase
    led_nx_s  = (state_nx_s == ST_ON);
    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  assign gnt_o  = gnt_r;
  assign done_o = done_r;
  assign busy_o = busy_r;
  assign led_o  = led_r;

endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares the board's single status LED among several requesters, each asking for a burst of N blinks. It performs round-robin arbitration, owns the blink-rate prescaler and sequences the LED through on/off phases. It then signals completion to the granted requester. It sits between the status sources (e.g. boot, error, heartbeat logic) and the LED pin.

## Interface
- NREQ, 4, number of requesters (2..8)
- TICK_DIV, 5_000_000, clock cycles per LED phase (half blink period), ≥2
- CNT_W, 4, width of each requester's blink-count field
- clk_i  input  1  system clock; all logic on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- req_i  input  NREQ  level request per requester
- cnt_i  input  NREQ*CNT_W  blink count; requester i uses bits [i*CNT_W +: CNT_W]
- gnt_o  output  NREQ  one-hot grant, held for the whole sequence
- done_o  output  NREQ  one-cycle completion pulse to the granted requester
- busy_o  output  1  high whenever the state is not IDLE
- led_o  output  1  LED drive, high = lit

## Operation
- Reset (asynchronous assert of rst_ni low):
  - State IDLE; all outputs 0; tick counter 0; remaining-count register 0.
  - Round-robin pointer set so requester 0 has highest priority next.
  - Reset mid-sequence aborts immediately. No done_o is issued.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - If any req_i bit is high, select the first high bit searching upward (with wrap) from last_granted+1.
  - Latch cnt_i of the selected requester; a count of 0 is treated as 1.
  - Assert the one-hot gnt_o and set last_granted to the selected index.
  - Enter ON.
- ON: led_o=1 for TICK_DIV cycles, then enter OFF.
- OFF: led_o=0 for TICK_DIV cycles.
  - Decrement the remaining count.
  - If the result is nonzero, enter ON; otherwise enter GAP.
- GAP: led_o=0 for 2*TICK_DIV cycles (inter-burst separation), then return to IDLE.
  - On that same edge: pulse done_o for the granted index for one cycle and clear gnt_o.
- Tick counter:
  - Width $clog2(2*TICK_DIV).
  - Cleared on every state entry; the phase ends when it reaches phase_length-1.
- Requests:
  - req_i is sampled only in IDLE. Changes to req_i or cnt_i during a sequence are ignored.
  - A requester that drops req_i mid-sequence still receives its full burst and its done_o.
  - A requester keeps req_i high until it sees done_o, and must drop it in the done_o cycle.
  - A req_i still high in the cycle after done_o counts as a new request.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Request to grant: req_i high before edge k while in IDLE → gnt_o, busy_o and led_o=1 valid after edge k.
- Sequence length for an effective count N: 2*N*TICK_DIV + 2*TICK_DIV cycles from the grant edge to the done edge.
- done_o, gnt_o clear and busy_o=0 occur together after the final GAP edge.
- The next grant comes no earlier than the following edge, so back-to-back requesters have one IDLE cycle between sequences.
- led_o rises exactly on ON entry and falls exactly on OFF entry; no glitches.
- Simultaneous requests are resolved in a single cycle by the round-robin order. A continuously requesting source can never starve another.

## Test plan
All scenarios use NREQ=4, TICK_DIV=4, CNT_W=4.
- Reset:
  - Stimulus: hold rst_ni low, then release with no requests.
  - Required response: all outputs 0 and busy_o stays 0 for 20 cycles.
- Single request:
  - Stimulus: req_i=0001 with cnt=2.
  - Required response: gnt_o=0001 after the next edge. led_o pattern is 4 high, 4 low, 4 high, 4 low, then 8 low (GAP). done_o[0] pulses exactly 24 cycles after the grant edge.
- Zero count:
  - Stimulus: req_i=0100 with cnt=0.
  - Required response: one blink (4 high, 4 low), 8 GAP cycles, done_o[2] at 16 cycles.
- Round robin:
  - Stimulus: req_i=1111 held, each requester dropping its req_i on its own done_o, all cnt=1.
  - Required response: grant order is 0,1,2,3, with exactly one IDLE cycle between sequences.
- Pointer wrap:
  - Stimulus: after granting requester 3, assert req_i=1001.
  - Required response: requester 0 is granted next.
- Mid-sequence events:
  - Stimulus A: drop req_i during ON. Required response: the burst completes and done_o still pulses.
  - Stimulus B: assert rst_ni low during OFF. Required response: led_o, gnt_o and busy_o drop immediately, with no done_o pulse.
